// File: rtl/online_relu_otfc_pkg.sv
// Shared definitions for the online ReLU / on-the-fly conversion stage:
// signed-digit encodings, FSM states and the digit decoder.
package online_relu_otfc_pkg;

    localparam logic [1:0] DIG_POS = 2'b10;
    localparam logic [1:0] DIG_NEG = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CONV,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic nonzero;
        logic negative;
    } digit_t;

    // 00 and 11 both decode to zero.
    function automatic digit_t decode_digit(input logic p, input logic n);
        digit_t d;
        d.nonzero  = ({p, n} == DIG_POS) || ({p, n} == DIG_NEG);
        d.negative = ({p, n} == DIG_NEG);
        return d;
    endfunction

endpackage

// File: rtl/online_relu_otfc_if.sv
// Digit-stream input and converted-result output bundle of the ReLU/OTFC stage.
interface online_relu_otfc_if #(
    parameter int unsigned N = 16
);
    logic         start;
    logic         z_p;
    logic         z_n;
    logic [N-1:0] y;
    logic         y_valid;
    logic         neg_term;
    logic         busy;

    modport master (
        output start, z_p, z_n,
        input  y, y_valid, neg_term, busy
    );

    modport slave (
        input  start, z_p, z_n,
        output y, y_valid, neg_term, busy
    );
endinterface

// File: rtl/online_relu_otfc_conv.sv
// Radix-2 signed-digit on-the-fly converter: Q holds the value, QM holds value - ulp.
// q_step_c is the Q that the current digit would produce, independent of en/clr.
module otfc_conv
    import online_relu_otfc_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [1:0]   digit,
    output logic [N-1:0] q,
    output logic [N-1:0] q_step_c
);

    logic [N-1:0] qm;
    logic [N-1:0] qm_step;
    digit_t       dec;

    // Shift-left-and-append selection between Q and QM.
    always_comb begin
        dec      = decode_digit(digit[1], digit[0]);
        q_step_c = {q[N-2:0], 1'b0};
        qm_step  = {qm[N-2:0], 1'b1};
        if (dec.nonzero && !dec.negative) begin
            q_step_c = {q[N-2:0], 1'b1};
            qm_step  = {q[N-2:0], 1'b0};
        end else if (dec.negative) begin
            q_step_c = {qm[N-2:0], 1'b1};
            qm_step  = {qm[N-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q  <= '0;
            qm <= '0;
        end else if (clr) begin
            q  <= '0;
            qm <= '1;
        end else if (en) begin
            q  <= q_step_c;
            qm <= qm_step;
        end
    end

endmodule

// File: rtl/online_relu_otfc.sv
// ReLU on an MSB-first signed-digit stream: terminates early when the leading
// nonzero digit is negative, otherwise converts N digits to an unsigned fraction.
module online_relu_otfc
    import online_relu_otfc_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned DELTA = 10,
    parameter int unsigned CW    = 6
) (
    input  logic              clk,
    input  logic              rst,
    online_relu_otfc_if.slave bus
);

    localparam int unsigned WAIT_LAST = (DELTA > 1) ? DELTA - 2 : 0;
    localparam int unsigned N_LAST    = N - 1;
    localparam state_t      ST_FIRST  = (DELTA > 1) ? ST_WAIT : ST_CONV;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          lead, lead_nx;
    logic [N-1:0]  y_r, y_nx;
    logic          y_valid_r, y_valid_nx;
    logic          neg_r, neg_nx;
    logic          busy_r, busy_nx;
    logic          otfc_clr_c, otfc_en_c;
    logic [N-1:0]  q, q_step_c;
    logic [1:0]    digit;
    digit_t        dec;

    assign digit = {bus.z_p, bus.z_n};

    otfc_conv #(.N(N)) u_conv (
        .clk      (clk),
        .rst      (rst),
        .clr      (otfc_clr_c),
        .en       (otfc_en_c),
        .digit    (digit),
        .q        (q),
        .q_step_c (q_step_c)
    );

    // Next-state and next-output logic; a start pulse overrides every state.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        lead_nx    = lead;
        y_nx       = y_r;
        y_valid_nx = 1'b0;
        neg_nx     = neg_r;
        otfc_clr_c = 1'b0;
        otfc_en_c  = 1'b0;
        dec        = decode_digit(bus.z_p, bus.z_n);

        if (bus.start) begin
            state_nx   = ST_FIRST;
            cnt_nx     = '0;
            lead_nx    = 1'b0;
            neg_nx     = 1'b0;
            otfc_clr_c = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: ;
                ST_WAIT: begin
                    if (cnt == CW'(WAIT_LAST)) begin
                        state_nx = ST_CONV;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                ST_CONV: begin
                    cnt_nx = cnt + CW'(1);
                    if (!lead && dec.negative) begin
                        neg_nx     = 1'b1;
                        y_nx       = '0;
                        y_valid_nx = 1'b1;
                        state_nx   = ST_DONE;
                    end else begin
                        otfc_en_c = 1'b1;
                        lead_nx   = lead | dec.nonzero;
                        if (cnt == CW'(N_LAST)) begin
                            y_nx       = q_step_c;
                            y_valid_nx = 1'b1;
                            state_nx   = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end

        busy_nx = (state_nx == ST_WAIT) || (state_nx == ST_CONV);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lead      <= 1'b0;
            y_r       <= '0;
            y_valid_r <= 1'b0;
            neg_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            lead      <= lead_nx;
            y_r       <= y_nx;
            y_valid_r <= y_valid_nx;
            neg_r     <= neg_nx;
            busy_r    <= busy_nx;
        end
    end

    assign bus.y        = y_r;
    assign bus.y_valid  = y_valid_r;
    assign bus.neg_term = neg_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_online_relu_otfc.sv
// Scoreboard bench for online_relu_otfc (N=8, DELTA=2): a reference model
// predicts y, neg_term and latency for each stream; results are checked on y_valid.
module tb_online_relu_otfc;

    localparam int unsigned N     = 8;
    localparam int unsigned DELTA = 2;
    localparam int unsigned CW    = 4;
    localparam logic [1:0]  P     = 2'b10;
    localparam logic [1:0]  M     = 2'b01;
    localparam logic [1:0]  Z     = 2'b00;
    localparam logic [1:0]  O     = 2'b11;

    typedef logic [N-1:0][1:0] stream_t;
    typedef struct {
        logic [N-1:0] y;
        logic         neg;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    online_relu_otfc_if #(.N(N)) bus ();

    online_relu_otfc #(.N(N), .DELTA(DELTA), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_vec     = 0;
    int   n_err     = 0;
    int   n_push    = 0;
    int   n_valid   = 0;
    int   cyc       = 0;
    int   start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: value = sum d_i * 2^(N-i); first nonzero digit negative -> zero result.
    function automatic exp_t model(input stream_t s);
        exp_t e;
        int   val;
        logic lead;
        logic [1:0] d;
        val   = 0;
        lead  = 1'b0;
        e.neg = 1'b0;
        e.lat = DELTA + N - 1;
        for (int i = 0; i < N; i++) begin
            if (!e.neg) begin
                d = s[N-1-i];
                if (d == P) begin
                    val  = val * 2 + 1;
                    lead = 1'b1;
                end else if (d == M) begin
                    if (!lead) begin
                        e.neg = 1'b1;
                        e.lat = DELTA + i;
                    end else begin
                        val = val * 2 - 1;
                    end
                end else begin
                    val = val * 2;
                end
            end
        end
        e.y = e.neg ? '0 : N'(val);
        return e;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus.start) start_cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.y_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                check("spurious_y_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("y", bus.y, e.y);
                check("neg_term", bus.neg_term, e.neg);
                check("latency", cyc - start_cyc, e.lat);
                check("busy_at_result", bus.busy, 1'b0);
            end
        end
    end

    // Called at a negedge; start is sampled on the next posedge, digit i on edge DELTA+i-1 later.
    task automatic send(input stream_t s, input int ndig, input bit expect_res);
        bus.start = 1'b1;
        bus.z_p   = 1'b0;
        bus.z_n   = 1'b0;
        if (expect_res) begin
            sb.push_back(model(s));
            n_push++;
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (DELTA - 1) @(negedge clk);
        for (int i = 0; i < ndig; i++) begin
            {bus.z_p, bus.z_n} = s[N-1-i];
            @(negedge clk);
        end
        bus.z_p = 1'b0;
        bus.z_n = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        stream_t s;
        bus.start = 1'b0;
        bus.z_p   = 1'b0;
        bus.z_n   = 1'b0;

        // Reset, with start asserted during reset (must be ignored).
        idle(2);
        bus.start = 1'b1;
        idle(2);
        check("reset_y", bus.y, 8'h00);
        check("reset_y_valid", bus.y_valid, 1'b0);
        check("reset_neg_term", bus.neg_term, 1'b0);
        check("reset_busy", bus.busy, 1'b0);
        bus.start = 1'b0;
        rst = 1'b0;
        idle(2);
        check("busy_after_reset_start", bus.busy, 1'b0);

        send({P, Z, M, Z, Z, Z, Z, Z}, N, 1'b1);    // 0x60
        idle(2);
        send({Z, Z, M, P, P, M, P, Z}, N, 1'b1);    // negative at digit 3
        idle(1);
        check("busy_after_neg", bus.busy, 1'b0);
        idle(1);
        send({Z, O, Z, O, Z, Z, O, Z}, N, 1'b1);    // all zero
        idle(2);
        send({P, P, P, P, P, P, P, P}, N, 1'b1);    // 0xFF
        idle(2);
        send({P, M, M, M, M, M, M, M}, N, 1'b1);    // 0x01
        idle(2);

        // Restart at digit 4 of a positive stream: only the new stream reports.
        send({P, P, Z, P, Z, Z, Z, Z}, 3, 1'b0);
        send({P, P, Z, Z, Z, Z, Z, Z}, N, 1'b1);    // 0xC0
        idle(2);

        // Restart coinciding with the last digit: no result for the aborted stream.
        send({P, Z, Z, Z, Z, Z, Z, P}, N - 1, 1'b0);
        send({Z, P, M, Z, P, Z, Z, Z}, N, 1'b1);
        idle(2);

        // Async reset mid-conversion, between clock edges.
        send({P, Z, M, Z, Z, Z, Z, Z}, N, 1'b1);
        idle(2);
        send({P, P, P, P, Z, Z, Z, Z}, 4, 1'b0);
        check("y_held_before_reset", bus.y, 8'h60);
        check("busy_before_reset", bus.busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_y", bus.y, 8'h00);
        check("async_rst_y_valid", bus.y_valid, 1'b0);
        check("async_rst_neg_term", bus.neg_term, 1'b0);
        check("async_rst_busy", bus.busy, 1'b0);
        idle(1);
        rst = 1'b0;
        idle(1);
        send({Z, P, Z, M, P, Z, M, P}, N, 1'b1);
        idle(2);

        // Random streams.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++) s[i] = 2'($urandom_range(0, 3));
            send(s, N, 1'b1);
            idle(1);
        end

        idle(5);
        check("scoreboard_empty", sb.size(), 0);
        check("result_count", n_valid, n_push);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule

// File: doc/online_relu_otfc.md
Name: online_relu_otfc

Overview:
- Downstream consumer of the online-arithmetic adder tree's signed-digit output stream (z_p/z_n, MSB first).
- Applies ReLU with early negative detection: the first nonzero digit decides the sign. A negative result terminates at once and outputs zero.
- Otherwise performs on-the-fly conversion (OTFC) of the radix-2 signed-digit stream into an N-bit unsigned fraction for the next layer.
- Asserts neg_term so upstream stages can stop computing early.

Parameters:
- N, 16, number of result digits converted; also the output width.
- DELTA, 10, online delay of the upstream tree, in cycles, from start to the first valid digit.
- CW, 6, counter width; must satisfy 2^CW > max(N, DELTA).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse: a new digit stream begins; the upstream tree starts on the same edge.
- z_p  input  1  positive rail of the incoming signed digit.
- z_n  input  1  negative rail of the incoming signed digit.
- y  output  N  converted ReLU result, unsigned fraction, value = y/2^N.
- y_valid  output  1  one-cycle pulse: y is final.
- neg_term  output  1  level: the current result was detected negative; held until the next start or reset.
- busy  output  1  high in WAIT and CONV.

Behaviour:
- Digit decode: (z_p,z_n) = 10 is +1; 01 is -1; 00 and 11 are 0.
- Reset (async) puts the FSM in IDLE and clears y, y_valid, neg_term, busy and all counters and OTFC registers.
- FSM states: IDLE, WAIT, CONV, DONE.
- IDLE: on start, go to WAIT; clear neg_term, lead_seen, Q, QM and the counter.
- WAIT: count DELTA-1 cycles, then go to CONV. With start sampled at edge k, digit i (i = 1..N) is sampled at edge k+DELTA+i-1.
- CONV: sample one digit per cycle and increment the digit counter.
  - While lead_seen=0, a 0 digit only shifts.
  - While lead_seen=0, a +1 digit sets lead_seen.
  - While lead_seen=0, a -1 digit means negative: on that same edge set neg_term=1, y=0, y_valid=1, and go to DONE. Remaining digits are ignored.
  - After the N-th digit: y=Q, y_valid=1, go to DONE. An all-zero stream gives y=0 and neg_term=0.
- OTFC update (N-bit registers, shift-left-and-append):
  - d=+1: Q<=Q<<1|1; QM<=Q<<1|0.
  - d=0: Q<=Q<<1|0; QM<=QM<<1|1.
  - d=-1: Q<=QM<<1|1; QM<=QM<<1|0.
  - Initial values: Q=0, QM=all ones. QM is never selected before lead_seen=1, so y is never negative.
- DONE: y_valid is high for exactly one cycle (the cycle after entry). y and neg_term hold. Go to IDLE.
- Latency: positive or zero result, y_valid is high in the cycle after edge k+DELTA+N-1. Negative result, y_valid is high in the cycle after the first -1 digit's edge.
- start in WAIT, CONV or DONE: abort the current operation and restart as from IDLE. No y_valid is issued for the aborted stream.
- start coincident with a result: the restart wins, and y_valid is suppressed.
- start during reset is ignored.

Decomposition:
- Shared package holds:
  - digit encoding constants DIG_POS=2'b10, DIG_NEG=2'b01;
  - the FSM state enum;
  - a function decoding (p,n) to {nonzero, negative}.
- One natural sub-module: otfc_conv, holding the Q/QM registers with inputs clr, en, digit and output Q. It is reusable by other converters.

Test Plan (N=8, DELTA=2):
- Positive mixed stream: start, then digits +1,0,-1,0,0,0,0,0 → y=8'h60 (0.375), neg_term=0, y_valid 10 cycles after start.
- Negative stream: digits 0,0,-1,+1,... → at the 3rd digit y_valid=1, y=8'h00, neg_term=1; later digits are ignored and busy drops.
- Boundaries:
  - All zeros (including 11 codes) → y=8'h00, neg_term=0.
  - All +1 → y=8'hFF.
  - +1 followed by seven -1 → y=8'h01.
- Abort: start again at digit 4 of a positive stream, then feed +1,+1,0,0,0,0,0,0 → exactly one y_valid, with y=8'hC0.
- Asynchronous reset mid-CONV (between clock edges) → all outputs 0 immediately; the next start converts a fresh stream correctly.
